// File: rtl/eth_frame_tx_arb.sv
// eth_frame_tx_arb: two-port round-robin arbiter that merges Ethernet header+payload streams onto one eth_axis_tx input
module eth_frame_tx_arb #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [1:0]              s_eth_hdr_valid,
   output logic [1:0]              s_eth_hdr_ready,
   input  logic [95:0]             s_eth_dest_mac,
   input  logic [95:0]             s_eth_src_mac,
   input  logic [31:0]             s_eth_type,
   input  logic [2*DATA_WIDTH-1:0] s_eth_payload_axis_tdata,
   input  logic [1:0]              s_eth_payload_axis_tvalid,
   input  logic [1:0]              s_eth_payload_axis_tlast,
   input  logic [1:0]              s_eth_payload_axis_tuser,
   output logic [1:0]              s_eth_payload_axis_tready,
   output logic                    m_eth_hdr_valid,
   input  logic                    m_eth_hdr_ready,
   output logic [47:0]             m_eth_dest_mac,
   output logic [47:0]             m_eth_src_mac,
   output logic [15:0]             m_eth_type,
   output logic [DATA_WIDTH-1:0]   m_eth_payload_axis_tdata,
   output logic                    m_eth_payload_axis_tvalid,
   output logic                    m_eth_payload_axis_tlast,
   output logic                    m_eth_payload_axis_tuser,
   input  logic                    m_eth_payload_axis_tready,
   output logic [1:0]              grant,
   output logic                    busy,
   output logic [15:0]             frame_count0,
   output logic [15:0]             frame_count1
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] HDR  = 2'd1;
   localparam logic [1:0] DATA = 2'd2;
   logic [1:0] state;
   logic       last_grant;
   logic       sel;
   logic       in_hdr;
   logic       in_data;
   logic       done;
   logic [1:0] win;
   assign sel     = grant[1];
   assign in_hdr  = state == HDR;
   assign in_data = state == DATA;
   assign busy    = state != IDLE;
   // on contention the port that did not own the last frame wins; last_grant is a port index
   assign win  = &s_eth_hdr_valid ? (last_grant ? 2'b01 : 2'b10) : s_eth_hdr_valid;
   assign done = in_data && s_eth_payload_axis_tvalid[sel] && s_eth_payload_axis_tlast[sel] && m_eth_payload_axis_tready;
   assign m_eth_hdr_valid = in_hdr && s_eth_hdr_valid[sel];
   assign s_eth_hdr_ready = in_hdr ? (grant & {2{m_eth_hdr_ready}}) : 2'b00;
   assign m_eth_dest_mac  = sel ? s_eth_dest_mac[95:48] : s_eth_dest_mac[47:0];
   assign m_eth_src_mac   = sel ? s_eth_src_mac[95:48] : s_eth_src_mac[47:0];
   assign m_eth_type      = sel ? s_eth_type[31:16] : s_eth_type[15:0];
   assign m_eth_payload_axis_tdata  = sel ? s_eth_payload_axis_tdata[2*DATA_WIDTH-1:DATA_WIDTH] : s_eth_payload_axis_tdata[DATA_WIDTH-1:0];
   assign m_eth_payload_axis_tvalid = in_data && s_eth_payload_axis_tvalid[sel];
   assign m_eth_payload_axis_tlast  = s_eth_payload_axis_tlast[sel];
   assign m_eth_payload_axis_tuser  = s_eth_payload_axis_tuser[sel];
   assign s_eth_payload_axis_tready = in_data ? (grant & {2{m_eth_payload_axis_tready}}) : 2'b00;
   // arbitration state, grant ownership and per-port completed-frame counters
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         grant        <= 2'b00;
         last_grant   <= 1'b1;
         frame_count0 <= 16'd0;
         frame_count1 <= 16'd0;
      end else if (state == IDLE && |s_eth_hdr_valid) begin
         state <= HDR;
         grant <= win;
      end else if (m_eth_hdr_valid && m_eth_hdr_ready) begin
         state <= DATA;
      end else if (done) begin
         state      <= IDLE;
         grant      <= 2'b00;
         last_grant <= sel;
         if (sel) frame_count1 <= frame_count1 + 16'd1;
         else frame_count0 <= frame_count0 + 16'd1;
      end
   end
endmodule
